bsg_mem_1rw_sync_mask_write_bit_master: RTL and testbench

BSG_MEM_1RW_SYNC_MASK_WRITE_BIT_MASTER -- requirements
Module: bsg_mem_1rw_sync_mask_write_bit_master

---
 rtl/bsg_mem_1rw_sync_mask_write_bit_master.sv | 149 ++++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_bit_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bsg_mem_1rw_sync_mask_write_bit_master                         |
// | Brief   : Credit-limited master for a 1rw sync mask-write-bit memory,    |
// |           with zero-fill sweep and a 2-entry read response FIFO.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_mem_1rw_sync_mask_write_bit_master
  #(parameter int width_p          = -1
   ,parameter int els_p            = -1
   ,parameter int addr_width_lp    = `BSG_SAFE_CLOG2(els_p)
   ,parameter bit clear_on_reset_p = 1
   )
   (input  logic                     clk_i
   ,input  logic                     reset_i

   ,input  logic                     v_i
   ,input  logic                     w_i
   ,input  logic [addr_width_lp-1:0] addr_i
   ,input  logic [width_p-1:0]       data_i
   ,input  logic [width_p-1:0]       w_mask_i
   ,output logic                     ready_o

   ,input  logic                     clear_i
   ,output logic                     clear_done_o

   ,output logic                     v_o
   ,output logic [width_p-1:0]       data_o
   ,input  logic                     yumi_i

   ,output logic                     mem_v_o
   ,output logic                     mem_w_o
   ,output logic [addr_width_lp-1:0] mem_addr_o
   ,output logic [width_p-1:0]       mem_data_o
   ,output logic [width_p-1:0]       mem_w_mask_o
   ,input  logic [width_p-1:0]       mem_data_i
   );

   typedef enum logic [0:0] {CLEAR = 1'b0, READY = 1'b1} state_e;

   localparam state_e c_RESET_STATE = clear_on_reset_p ? CLEAR : READY;

   state_e                   r_state;
   logic [addr_width_lp-1:0] r_sweep_addr;
   logic [1:0]               r_credit;
   logic                     r_rd_pending;
   logic [width_p-1:0]       r_fifo [2];
   logic                     r_wr_ptr;
   logic                     r_rd_ptr;
   logic [1:0]               r_fifo_cnt;

   logic w_accept, w_rd_accept, w_enq, w_deq, w_clear_go, w_sweep_last;

   // Reset gates every handshake output so nothing is presented mid-reset.
   assign clear_done_o = (r_state == READY) & ~reset_i;
   assign ready_o      = (r_state == READY) & (r_credit < 2'd2) & ~clear_i & ~reset_i;
   assign v_o          = (r_fifo_cnt != 2'd0) & ~reset_i;
   assign data_o       = r_fifo[r_rd_ptr];

   assign w_accept     = v_i & ready_o;
   assign w_rd_accept  = w_accept & ~w_i;
   assign w_enq        = r_rd_pending;
   assign w_deq        = v_o & yumi_i;
   assign w_clear_go   = (r_state == READY) & clear_i & (r_credit == 2'd0) & ~reset_i;
   assign w_sweep_last = (r_sweep_addr == addr_width_lp'(els_p - 1));

   always_comb begin
      if (r_state == CLEAR) begin
         mem_v_o      = ~reset_i;
         mem_w_o      = 1'b1;
         mem_addr_o   = r_sweep_addr;
         mem_data_o   = '0;
         mem_w_mask_o = '1;
      end else begin
         mem_v_o      = w_accept;
         mem_w_o      = w_i;
         mem_addr_o   = addr_i;
         mem_data_o   = data_i;
         mem_w_mask_o = w_mask_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state      <= c_RESET_STATE;
         r_sweep_addr <= '0;
         r_credit     <= 2'd0;
         r_rd_pending <= 1'b0;
         r_wr_ptr     <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_fifo_cnt   <= 2'd0;
      end else begin
         case (r_state)
            CLEAR: begin
               if (w_sweep_last) begin
                  r_state      <= READY;
                  r_sweep_addr <= '0;
               end else begin
                  r_sweep_addr <= r_sweep_addr + addr_width_lp'(1);
               end
            end
            READY: begin
               if (w_clear_go) begin
                  r_state      <= CLEAR;
                  r_sweep_addr <= '0;
               end
            end
            default: r_state <= c_RESET_STATE;
         endcase

         // Memory has one cycle of read latency; capture data the cycle after.
         r_rd_pending <= w_rd_accept;

         case ({w_rd_accept, w_deq})
            2'b10:   r_credit <= r_credit + 2'd1;
            2'b01:   r_credit <= r_credit - 2'd1;
            default: r_credit <= r_credit;
         endcase

         if (w_enq) r_wr_ptr <= ~r_wr_ptr;
         if (w_deq) r_rd_ptr <= ~r_rd_ptr;

         case ({w_enq, w_deq})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_enq) r_fifo[r_wr_ptr] <= mem_data_i;
   end

`ifndef SYNTHESIS
   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      !(yumi_i && !v_o));
   a_addr_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
      !(w_accept && (int'(addr_i) >= els_p)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bsg_mem_1rw_sync_mask_write_bit_master                      |
// | Brief   : Scoreboard bench with a behavioural mask-write-bit memory.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_bsg_mem_1rw_sync_mask_write_bit_master;

   localparam int W = 8;
   localparam int E = 4;
   localparam int A = 2;

   logic         clk = 1'b0;
   logic         reset_i, v_i, w_i, clear_i, yumi_i;
   logic [A-1:0] addr_i;
   logic [W-1:0] data_i, w_mask_i;
   logic         ready_o, clear_done_o, v_o;
   logic [W-1:0] data_o;
   logic         mem_v_o, mem_w_o;
   logic [A-1:0] mem_addr_o;
   logic [W-1:0] mem_data_o, mem_w_mask_o;
   logic [W-1:0] mem_data_i;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q [$];

   // Non-zero power-up contents make the zero-fill sweep observable.
   logic [W-1:0] r_mem [E] = '{8'hEE, 8'hEE, 8'hEE, 8'hEE};

   always #5 clk = ~clk;

   bsg_mem_1rw_sync_mask_write_bit_master
     #(.width_p(W), .els_p(E), .clear_on_reset_p(1'b1))
   dut
     (.clk_i(clk), .reset_i(reset_i)
     ,.v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i), .w_mask_i(w_mask_i)
     ,.ready_o(ready_o)
     ,.clear_i(clear_i), .clear_done_o(clear_done_o)
     ,.v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
     ,.mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o)
     ,.mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
     );

   always @(posedge clk) begin
      if (mem_v_o) begin
         if (mem_w_o)
            r_mem[mem_addr_o] <= (r_mem[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
         else
            mem_data_i <= r_mem[mem_addr_o];
      end
   end

   // Response monitor: every consumed response is checked against the queue.
   always @(negedge clk) begin
      if (!reset_i && v_o && yumi_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mon_unexpected actual=%0h required=no_response", data_o);
         end else begin
            logic [W-1:0] exp;
            exp = exp_q.pop_front();
            if (data_o !== exp) begin
               errors++;
               $display("FAIL mon_data actual=%0h required=%0h", data_o, exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
      v_i = 1'b1; w_i = 1'b1; addr_i = a; data_i = d; w_mask_i = m;
      @(negedge clk);
      chk("wr_ready", ready_o, 1);
      chk("wr_mem_v", mem_v_o, 1);
      chk("wr_mem_w", mem_w_o, 1);
      chk("wr_mem_addr", mem_addr_o, a);
      chk("wr_mem_data", mem_data_o, d);
      chk("wr_mem_mask", mem_w_mask_o, m);
      step();
      v_i = 1'b0; w_i = 1'b0;
   endtask

   task automatic do_read(input logic [A-1:0] a, input logic [W-1:0] exp);
      v_i = 1'b1; w_i = 1'b0; addr_i = a;
      @(negedge clk);
      chk("rd_ready", ready_o, 1);
      chk("rd_mem_v", mem_v_o, 1);
      chk("rd_mem_w", mem_w_o, 0);
      chk("rd_mem_addr", mem_addr_o, a);
      exp_q.push_back(exp);
      step();
      v_i = 1'b0;
   endtask

   task automatic consume(input string name);
      chk({name, "_v"}, v_o, 1);
      if (v_o === 1'b1) yumi_i = 1'b1;
      @(negedge clk);
      step();
      yumi_i = 1'b0;
   endtask

   task automatic sweep_check(input string tag);
      for (int i = 0; i < E; i++) begin
         @(negedge clk);
         chk({tag, "_mem_v"}, mem_v_o, 1);
         chk({tag, "_mem_w"}, mem_w_o, 1);
         chk({tag, "_mem_addr"}, mem_addr_o, i);
         chk({tag, "_mem_data"}, mem_data_o, 8'h00);
         chk({tag, "_mem_mask"}, mem_w_mask_o, 8'hFF);
         chk({tag, "_ready"}, ready_o, 0);
         chk({tag, "_done"}, clear_done_o, 0);
         chk({tag, "_v_o"}, v_o, 0);
         step();
      end
      @(negedge clk);
      chk({tag, "_done_end"}, clear_done_o, 1);
      chk({tag, "_ready_end"}, ready_o, 1);
      chk({tag, "_v_end"}, v_o, 0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1; v_i = 1'b0; w_i = 1'b0; clear_i = 1'b0; yumi_i = 1'b0;
      addr_i = '0; data_i = '0; w_mask_i = '0;
      step(); step();
      @(negedge clk);
      chk("rst_ready", ready_o, 0);
      chk("rst_v", v_o, 0);
      chk("rst_mem_v", mem_v_o, 0);
      chk("rst_done", clear_done_o, 0);
      step();
      reset_i = 1'b0;
      sweep_check("init");

      // Masked write then read back: 0xA5 under mask 0x0F over cleared 0x00.
      do_write(2'd2, 8'hA5, 8'h0F);
      do_write(2'd1, 8'h3C, 8'hFF);
      do_write(2'd3, 8'hFF, 8'hF0);
      do_read(2'd2, 8'h05);
      @(negedge clk); chk("lat_n1_v", v_o, 0); chk("lat_n1_mem_v", mem_v_o, 0); step();
      @(negedge clk); chk("lat_n2_v", v_o, 1); chk("lat_n2_data", data_o, 8'h05); step();
      consume("lat");

      // Two reads with no yumi exhaust credit; a write attempt is refused.
      do_read(2'd2, 8'h05);
      do_read(2'd3, 8'hF0);
      v_i = 1'b1; w_i = 1'b1; addr_i = 2'd0; data_i = 8'h77; w_mask_i = 8'hFF;
      @(negedge clk);
      chk("full_ready", ready_o, 0);
      chk("full_mem_v", mem_v_o, 0);
      chk("full_v", v_o, 1);
      chk("full_data", data_o, 8'h05);
      step();
      v_i = 1'b0; w_i = 1'b0;
      @(negedge clk); chk("hold_ready", ready_o, 0); chk("hold_data", data_o, 8'h05); step();
      consume("b2b_first");
      @(negedge clk); chk("post_yumi_ready", ready_o, 1); chk("post_yumi_data", data_o, 8'hF0); step();
      consume("b2b_second");

      // Read accept and yumi in the same cycle keep the credit count.
      do_read(2'd1, 8'h3C);
      step();
      v_i = 1'b1; w_i = 1'b0; addr_i = 2'd3;
      chk("same_v", v_o, 1);
      if (v_o === 1'b1) yumi_i = 1'b1;
      @(negedge clk);
      chk("same_ready", ready_o, 1);
      chk("same_mem_v", mem_v_o, 1);
      exp_q.push_back(8'hF0);
      step();
      v_i = 1'b0; yumi_i = 1'b0;
      @(negedge clk); chk("same_ready_next", ready_o, 1); chk("same_v_next", v_o, 0); step();
      consume("same_second");

      // The refused write must not have landed.
      do_read(2'd0, 8'h00);
      step();
      consume("blocked_wr");

      // Clear requested with a read outstanding waits for the yumi.
      do_read(2'd1, 8'h3C);
      clear_i = 1'b1;
      @(negedge clk);
      chk("clrpend_ready", ready_o, 0);
      chk("clrpend_mem_v", mem_v_o, 0);
      chk("clrpend_done", clear_done_o, 1);
      step();
      @(negedge clk); chk("clrpend_mem_v2", mem_v_o, 0); chk("clrpend_done2", clear_done_o, 1); step();
      consume("clrpend");
      v_i = 1'b1; w_i = 1'b0; addr_i = 2'd2;
      @(negedge clk);
      chk("clr_prio_ready", ready_o, 0);
      chk("clr_prio_mem_v", mem_v_o, 0);
      chk("clr_prio_done", clear_done_o, 1);
      step();
      v_i = 1'b0; clear_i = 1'b0;
      sweep_check("reclear");
      do_read(2'd1, 8'h00);
      do_read(2'd3, 8'h00);
      consume("zero_a");
      consume("zero_b");

      // Reset during sweep address 2 restarts the sweep from 0.
      clear_i = 1'b1;
      @(negedge clk); chk("clr2_ready", ready_o, 0); step();
      clear_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("intr_mem_v", mem_v_o, 1);
         chk("intr_mem_addr", mem_addr_o, i);
         step();
      end
      reset_i = 1'b1;
      @(negedge clk);
      chk("intr_addr2", mem_addr_o, 2);
      chk("intr_rst_mem_v", mem_v_o, 0);
      chk("intr_rst_done", clear_done_o, 0);
      step();
      reset_i = 1'b0;
      sweep_check("restart");

      // An in-flight read is discarded by reset.
      v_i = 1'b1; w_i = 1'b0; addr_i = 2'd0;
      step();
      v_i = 1'b0; reset_i = 1'b1;
      @(negedge clk); chk("flight_rst_v", v_o, 0); step();
      reset_i = 1'b0;
      sweep_check("flight");

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
